bram_capture_ctrl: RTL

//  Sequences trigger-armed sample capture into a 32-bit-wide BRAM port.

---
 rtl/bram_capture_if.sv | 48 ++++
 rtl/bram_capture_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bram_capture_if.sv
// Bundles the capture controller's control inputs, sample stream and BRAM
// port-A write signals.
// Optional feature macro: CAPTURE_DECIM_EN adds the decim[15:0] input.
//
// Modports:
//   master : the side that drives arm/abort/trigger/samples/cap_len and
//            watches the BRAM write port and status.
//   slave  : the capture controller itself.
interface bram_capture_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
);
    logic                  arm;
    logic                  abort;
    logic                  trigger;
    logic                  sample_valid;
    logic [DATA_WIDTH-1:0] sample_data;
    logic [ADDR_WIDTH-1:0] cap_len;
`ifdef CAPTURE_DECIM_EN
    logic [15:0]           decim;
`endif
    logic [31:0]           bram_addr;
    logic [31:0]           bram_wdata;
    logic [3:0]            bram_wen;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] wr_count;

`ifdef CAPTURE_DECIM_EN
    modport master (
        output arm, abort, trigger, sample_valid, sample_data, cap_len, decim,
        input  bram_addr, bram_wdata, bram_wen, busy, done, wr_count
    );
    modport slave (
        input  arm, abort, trigger, sample_valid, sample_data, cap_len, decim,
        output bram_addr, bram_wdata, bram_wen, busy, done, wr_count
    );
`else
    modport master (
        output arm, abort, trigger, sample_valid, sample_data, cap_len,
        input  bram_addr, bram_wdata, bram_wen, busy, done, wr_count
    );
    modport slave (
        input  arm, abort, trigger, sample_valid, sample_data, cap_len,
        output bram_addr, bram_wdata, bram_wen, busy, done, wr_count
    );
`endif
endinterface

// File: rtl/bram_capture_ctrl.sv
// Trigger-armed sample capture into a 32-bit BRAM write port.
// Software arms the block; the next rising trigger edge starts a burst of
// cap_len writes at word addresses 0,1,2,... On the last write the block
// parks in DONE until re-armed. abort returns to IDLE from anywhere.
// Optional feature macro: CAPTURE_DECIM_EN (write every (decim+1)-th sample).
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : bram_capture_if.slave (arm/abort/trigger/sample stream/cap_len in,
//          bram_addr/bram_wdata/bram_wen/busy/done/wr_count out)
//
// state     | meaning
// ----------+-----------------------------------------------------
// S_IDLE    | inactive, waiting for arm
// S_ARMED   | length latched, waiting for a fresh trigger rising edge
// S_CAPTURE | writing valid samples to consecutive word addresses
// S_DONE    | last write issued, waiting for re-arm
module bram_capture_ctrl #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    bram_capture_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  trig_d;
    logic                  trig_edge;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [ADDR_WIDTH-1:0] wr_count_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  wen_q;
    logic [31:0]           sample_ext;
    logic [31:0]           addr_ext;
    logic                  do_arm;
    logic                  do_write;
    logic                  start_cap;
    logic                  dec_adv;
    logic                  dec_hit;

    assign trig_edge = bus.trigger & ~trig_d;
    // Length 0 wraps to all-ones here, i.e. a full-depth capture.
    assign last_idx  = len_q - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

`ifdef CAPTURE_DECIM_EN
    logic [15:0] decim_q;
    logic [15:0] dec_cnt_q;

    assign dec_hit = (dec_cnt_q == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            decim_q   <= '0;
            dec_cnt_q <= '0;
        end else begin
            if (do_arm)
                decim_q <= bus.decim;
            if (start_cap)
                dec_cnt_q <= '0;
            else if (dec_adv)
                dec_cnt_q <= (dec_cnt_q == decim_q) ? 16'd0 : dec_cnt_q + 16'd1;
        end
    end
`else
    assign dec_hit = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        do_arm    = 1'b0;
        do_write  = 1'b0;
        start_cap = 1'b0;
        dec_adv   = 1'b0;
        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.arm) begin
                        do_arm  = 1'b1;
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (trig_edge) begin
                        start_cap = 1'b1;
                        state_d   = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (bus.sample_valid) begin
                        dec_adv = 1'b1;
                        if (dec_hit) begin
                            do_write = 1'b1;
                            if (wr_count_q == last_idx)
                                state_d = S_DONE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        sample_ext                 = '0;
        sample_ext[DATA_WIDTH-1:0] = bus.sample_data;
        addr_ext                   = '0;
        addr_ext[ADDR_WIDTH+1:2]   = addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_d     <= 1'b0;
            len_q      <= '0;
            wr_count_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
        end else begin
            trig_d <= bus.trigger;
            wen_q  <= do_write;
            if (do_arm) begin
                len_q      <= bus.cap_len;
                wr_count_q <= '0;
            end
            if (do_write) begin
                addr_q     <= wr_count_q;
                wdata_q    <= sample_ext;
                wr_count_q <= wr_count_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.bram_addr  = addr_ext;
    assign bus.bram_wdata = wdata_q;
    assign bus.bram_wen   = wen_q ? 4'hF : 4'h0;
    assign bus.busy       = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.wr_count   = wr_count_q;

endmodule
